// File: rtl/stripe_defs_pkg.sv
// Shared lane-striping definitions for the 1:4 demux and 4:1 mux.
// Lane count, index width and valid-mask constants.
package stripe_defs_pkg;

  localparam int NLANES     = 4;
  localparam int LANE_IDX_W = 2;
  localparam int BYTE_W     = 8;

  localparam logic [NLANES-1:0] VALID_ALL  = 4'b1111;
  localparam logic [NLANES-1:0] VALID_NONE = 4'b0000;

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;
  typedef logic [NLANES-2:0]     fill_mask_t;

endpackage

// File: rtl/demux_lane_ptr.sv
// Lane pointer and fill mask for the 1:4 stripe demux.
// Decides when a full or partial group is emitted.
module demux_lane_ptr
  import stripe_defs_pkg::*;
(
  input  logic       clk4f,
  input  logic       reset,
  input  logic       valid,
  input  logic       flush,
  output lane_idx_t  ptr,
  output fill_mask_t fmask,
  output fill_mask_t emask,
  output logic       complete,
  output logic       emit
);

  lane_idx_t  ptr_d;
  fill_mask_t fmask_d;
  fill_mask_t hit;

  always_comb begin
    complete = valid && (ptr == lane_idx_t'(NLANES - 1));
    hit      = '0;
    if (valid && !complete)
      hit = fill_mask_t'(1) << ptr;
    // mask after this cycle's byte is taken in
    emask    = fmask | hit;
    emit     = complete || (flush && (emask != '0));
    ptr_d    = ptr;
    fmask_d  = fmask;
    if (emit) begin
      ptr_d   = '0;
      fmask_d = '0;
    end else if (valid) begin
      ptr_d   = ptr + 1'b1;
      fmask_d = emask;
    end
  end

  always_ff @(posedge clk4f or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      fmask <= '0;
    end else begin
      ptr   <= ptr_d;
      fmask <= fmask_d;
    end
  end

endmodule

// File: rtl/demux1x4_stripe.sv
// 1:4 byte stripe demux: round-robin bytes into 4 lanes, emit per group.
// Optional group counter output enabled by DEMUX_GRPCNT_EN.
module demux1x4_stripe
  import stripe_defs_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NLANES = 4
) (
  input  logic              clk4f,
  input  logic              reset,
  input  logic [DATA_W-1:0] in,
  input  logic              valid,
  input  logic              flush,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [3:0]        validout,
  output logic              grp_stb
`ifdef DEMUX_GRPCNT_EN
  ,
  output logic [15:0]       grp_count
`endif
);

  if (NLANES != 4) begin : g_bad_nlanes
    $error("demux1x4_stripe: NLANES must be 4");
  end

  lane_idx_t  ptr;
  fill_mask_t fmask;
  fill_mask_t emask;
  logic       complete;
  logic       emit;

  demux_lane_ptr u_ptr (
    .clk4f    (clk4f),
    .reset    (reset),
    .valid    (valid),
    .flush    (flush),
    .ptr      (ptr),
    .fmask    (fmask),
    .emask    (emask),
    .complete (complete),
    .emit     (emit)
  );

  logic [DATA_W-1:0] sh  [3];
  logic [DATA_W-1:0] ld  [4];
  logic [3:0]        vld;

  // unfilled lanes are forced to zero so stale shadows never leak
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ld[i] = '0;
      if (emask[i])
        ld[i] = (valid && ptr == lane_idx_t'(i)) ? in : sh[i];
    end
    ld[3] = complete ? in : '0;
    vld   = complete ? VALID_ALL : {1'b0, emask};
  end

  always_ff @(posedge clk4f or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++)
        sh[i] <= '0;
      out0     <= '0;
      out1     <= '0;
      out2     <= '0;
      out3     <= '0;
      validout <= VALID_NONE;
      grp_stb  <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (valid && !complete && ptr == lane_idx_t'(i))
          sh[i] <= in;
      grp_stb <= emit;
      if (emit) begin
        out0     <= ld[0];
        out1     <= ld[1];
        out2     <= ld[2];
        out3     <= ld[3];
        validout <= vld;
      end
    end
  end

`ifdef DEMUX_GRPCNT_EN
  always_ff @(posedge clk4f or negedge reset) begin
    if (!reset)
      grp_count <= '0;
    else if (emit)
      grp_count <= grp_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_demux1x4_stripe.sv
// Directed bench for demux1x4_stripe with an expected-group scoreboard.
// Group counter checks are compiled in with DEMUX_GRPCNT_EN.
module tb_demux1x4_stripe;

  logic       clk4f = 1'b0;
  logic       reset;
  logic [7:0] in_b;
  logic       valid;
  logic       flush;
  logic [7:0] out0, out1, out2, out3;
  logic [3:0] validout;
  logic       grp_stb;
`ifdef DEMUX_GRPCNT_EN
  logic [15:0] grp_count;
`endif

  demux1x4_stripe dut (
    .clk4f    (clk4f),
    .reset    (reset),
    .in       (in_b),
    .valid    (valid),
    .flush    (flush),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .validout (validout),
    .grp_stb  (grp_stb)
`ifdef DEMUX_GRPCNT_EN
    ,
    .grp_count(grp_count)
`endif
  );

  always #5 clk4f = ~clk4f;

  typedef struct packed {
    logic [7:0] o0;
    logic [7:0] o1;
    logic [7:0] o2;
    logic [7:0] o3;
    logic [3:0] v;
  } grp_t;

  grp_t sb[$];
  grp_t last;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d,
                      input logic [3:0] v);
    grp_t g;
    g = '{o0: a, o1: b, o2: c, o3: d, v: v};
    sb.push_back(g);
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic f);
    valid = v;
    in_b  = d;
    flush = f;
    @(posedge clk4f);
    #1;
    valid = 1'b0;
    flush = 1'b0;
    in_b  = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      cyc(1'b0, 8'h00, 1'b0);
  endtask

  grp_t obs_g;
  always_comb obs_g = '{o0: out0, o1: out1, o2: out2, o3: out3, v: validout};

  always @(negedge clk4f) begin
    if (!reset) begin
      chk("reset_outs", 64'(obs_g), 64'(0));
      chk("reset_stb", 64'(grp_stb), 64'(0));
      last = '0;
    end else if (grp_stb) begin
      if (sb.size() == 0) begin
        chk("unexpected_stb", 64'(1), 64'(0));
      end else begin
        grp_t e;
        e = sb.pop_front();
        chk("group", 64'(obs_g), 64'(e));
        last = e;
      end
    end else begin
      chk("hold", 64'(obs_g), 64'(last));
    end
  end

  initial begin
    reset = 1'b0;
    valid = 1'b0;
    flush = 1'b0;
    in_b  = 8'h00;
    repeat (3) @(posedge clk4f);
    #1;
    reset = 1'b1;
    idle(2);

    // full rate group
    push(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'b1111);
    cyc(1, 8'hA0, 0); cyc(1, 8'hA1, 0);
    cyc(1, 8'hA2, 0); cyc(1, 8'hA3, 0);
    idle(3);

    // same bytes with 2-cycle bubbles
    push(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'b1111);
    cyc(1, 8'hA0, 0); idle(2);
    cyc(1, 8'hA1, 0); idle(2);
    cyc(1, 8'hA2, 0); idle(2);
    cyc(1, 8'hA3, 0); idle(3);

    // partial flush, then next byte lands in lane 0
    push(8'h11, 8'h22, 8'h00, 8'h00, 4'b0011);
    cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(0, 8'h00, 1);
    idle(1);
    push(8'h33, 8'h00, 8'h00, 8'h00, 4'b0001);
    cyc(1, 8'h33, 0); cyc(0, 8'h00, 1);
    idle(1);

    // flush with nothing buffered is a no-op
    cyc(0, 8'h00, 1);
    idle(2);

    // valid+flush at ptr==1 includes the byte
    push(8'h66, 8'h77, 8'h00, 8'h00, 4'b0011);
    cyc(1, 8'h66, 0); cyc(1, 8'h77, 1);
    idle(2);

    // valid+flush completing a group gives one full strobe
    push(8'h01, 8'h02, 8'h03, 8'h04, 4'b1111);
    cyc(1, 8'h01, 0); cyc(1, 8'h02, 0); cyc(1, 8'h03, 0);
    cyc(1, 8'h04, 1);
    idle(3);

    // back-to-back groups
    push(8'h50, 8'h51, 8'h52, 8'h53, 4'b1111);
    push(8'h60, 8'h61, 8'h62, 8'h63, 4'b1111);
    for (int i = 0; i < 4; i++) cyc(1, 8'h50 + 8'(i), 0);
    for (int i = 0; i < 4; i++) cyc(1, 8'h60 + 8'(i), 0);
    idle(2);

    // async reset mid-group discards buffered bytes
    cyc(1, 8'hC0, 0); cyc(1, 8'hC1, 0);
    reset = 1'b0;
    #1;
    chk("async_rst_out0", 64'(out0), 64'(0));
    chk("async_rst_valid", 64'(validout), 64'(0));
    #5;
    reset = 1'b1;
    @(posedge clk4f);
    #1;
    push(8'hB0, 8'h00, 8'h00, 8'h00, 4'b0001);
    cyc(1, 8'hB0, 1);
    push(8'hB0, 8'hB1, 8'hB2, 8'hB3, 4'b1111);
    cyc(1, 8'hB0, 0); cyc(1, 8'hB1, 0);
    cyc(1, 8'hB2, 0); cyc(1, 8'hB3, 0);
    idle(2);

`ifdef DEMUX_GRPCNT_EN
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    idle(1);
    chk("cnt_reset", 64'(grp_count), 64'(0));
    for (int g = 0; g < 3; g++) begin
      push(8'h10, 8'h11, 8'h12, 8'h13, 4'b1111);
      for (int i = 0; i < 4; i++) cyc(1, 8'h10 + 8'(i), 0);
    end
    push(8'h20, 8'h00, 8'h00, 8'h00, 4'b0001);
    cyc(1, 8'h20, 1);
    idle(1);
    chk("cnt_4", 64'(grp_count), 64'(4));
    for (int i = 0; i < 65531; i++) begin
      push(8'(i), 8'h00, 8'h00, 8'h00, 4'b0001);
      cyc(1, 8'(i), 1);
    end
    idle(1);
    chk("cnt_ffff", 64'(grp_count), 64'(16'hFFFF));
    push(8'h7E, 8'h00, 8'h00, 8'h00, 4'b0001);
    cyc(1, 8'h7E, 1);
    idle(1);
    chk("cnt_wrap", 64'(grp_count), 64'(0));
`endif

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1x4_stripe.md
Name: demux1x4_stripe

Overview:
- Byte un-multiplexer on the transmit side of the PHY striping path: the other end of the 4:1 lane-merging mux.
- Takes one serial byte+valid stream in the 4f domain and distributes consecutive valid bytes round-robin to lanes 0..3.
- Presents each completed 4-byte group on four parallel lane outputs with per-lane valid bits, all updated in a single cycle.
- Supports a flush that emits a partial group.

Parameters:
- DATA_W, 8, width of each byte/lane.
- NLANES, 4, number of lanes. Fixed at 4; any other value is rejected at elaboration.

Ports:
- clk4f  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset. The block is held in reset while reset==0.
- in  input  DATA_W  serial data byte.
- valid  input  1  in carries a valid byte this cycle.
- flush  input  1  one-cycle request to emit a partially filled group.
- out0, out1, out2, out3  output  DATA_W each  lane data outputs (registered).
- validout  output  4  per-lane valid; bit i qualifies out_i (registered).
- grp_stb  output  1  one-cycle pulse when out*/validout are updated.

Behaviour:
- Reset (reset==0, asynchronous): the following are all 0 and held while reset is low:
  - lane pointer ptr (2 bits);
  - shadow registers sh0..sh2 and fill mask fmask (3 bits);
  - out0..out3, validout, grp_stb.
- Accept, when valid==1 on an edge:
  - If ptr<3: the byte is stored in sh[ptr], fmask[ptr] is set, and ptr increments.
  - If ptr==3: the group is complete. In the same edge, out0..out2<=sh0..sh2, out3<=in, validout<=4'b1111, grp_stb<=1, ptr<=0, fmask<=0.
- Bubbles: valid==0 holds ptr, shadows and fmask. Gaps of any length between bytes are legal.
- Latency: the 4th byte is sampled at edge N. out*/validout/grp_stb are visible after edge N. Bytes 0–2 appear on outputs only when the group completes.
- Wrap-around: ptr wraps 3→0 only on group completion. The next valid byte always goes to lane 0.
- Output hold: out*/validout keep their values until the next group or flush. grp_stb is high for exactly one cycle per emitted group.
- Flush, with valid==0 and fmask!=0:
  - outputs load the shadow registers for filled lanes;
  - lanes not filled output 0;
  - validout={1'b0,fmask}, grp_stb=1, ptr<=0, fmask<=0.
- Flush with fmask==0 and valid==0: no-op. No strobe; outputs unchanged.
- Simultaneous valid and flush:
  - The byte is accepted first, then the flush applies to the resulting state.
  - If the byte completes the group (ptr==3), a normal full group is emitted (validout=4'b1111) and the flush is consumed.
  - Otherwise a partial group is emitted including that byte, e.g. ptr==1 gives validout=4'b0011.
- Back-to-back groups: the edge after a completion can accept a new byte into lane 0. A strobe every 4 cycles is possible at full rate.
- Reset mid-group: partially filled bytes are discarded and never emitted.
- Shadow contents of unfilled lanes never leak to outputs.

Optional Feature:
- Macro DEMUX_GRPCNT_EN.
- Defined: adds output grp_count, 16 bits, reset 0. It increments on every grp_stb (full or partial) and wraps 16'hFFFF→0.
- Not defined: the port and counter do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package/include (stripe_defs), included by this block and the 4:1 mux:
  - NLANES=4, LANE_IDX_W=2, BYTE_W=8;
  - constants VALID_ALL=4'b1111, VALID_NONE=4'b0000.
- One natural sub-module: demux_lane_ptr.
  - 2-bit pointer, fill mask, and "complete" flag.
  - Inputs: valid, flush. Outputs: ptr, fmask, complete, emit.
- The top level holds the shadow registers, the output registers and the optional counter.

Test Plan:
- Reset then stream 8'hA0,A1,A2,A3 on 4 consecutive cycles → after the 4th edge out0..3=A0,A1,A2,A3, validout=4'b1111, grp_stb high exactly 1 cycle.
- Same bytes with valid low for 2 cycles between each byte → identical group; grp_stb only after A3; outputs held meanwhile.
- Send 8'h11,22 then flush=1 → out0=11, out1=22, out2=out3=0, validout=4'b0011, grp_stb=1; the next byte 8'h33 goes to lane 0.
- With 3 bytes 8'h01,02,03 buffered, drive valid=1, in=8'h04 and flush=1 together → full group 01..04, validout=4'b1111, one strobe only.
- Load 2 bytes, pulse reset low asynchronously mid-cycle, release, send 8'hB0..B3 → outputs zero during reset; the group is exactly B0..B3 with no stale bytes.
- With DEMUX_GRPCNT_EN: 3 full groups plus 1 flush → grp_count=4. Preload the count to 16'hFFFF by running 65535 groups; the next group → grp_count=0.
